// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter and the cache controllers that talk to it.
// Holds the arbiter state encoding, requester indices and default bus widths.
// Ports: none (package).
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_LINE_WIDTH = 2048;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requester index to its one-hot handshake lane.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
// Latency: purely combinational. Backpressure: none, it only selects.
// Ports: req[1:0], last_grant in; grant_valid, grant_idx out.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b11:   grant_idx = ~last_grant;
      2'b10:   grant_idx = REQ_DCACHE;
      default: grant_idx = REQ_ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the I-cache (0) and D-cache (1), one whole-line transaction at a time.
// Latency: request at T -> cmd_valid at T+1; bus_valid at T+m -> resp_valid at T+m+1 (3 cycles minimum).
// Backpressure: cmd is held stable until cmd_ready; requesters hold req_valid until their req_ready pulse.
// Ports: req_valid/req_store/req_addr/req_wdata in, req_ready out (per requester);
//        resp_valid (one-hot) and shared resp_data out; cmd_* out with cmd_ready in; bus_valid/bus_rdata in.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_store,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 resp_valid,
  output logic [LINE_WIDTH-1:0]      resp_data,
  output logic                       cmd_valid,
  output logic                       cmd_store,
  output logic [ADDR_WIDTH-1:0]      cmd_addr,
  output logic [LINE_WIDTH-1:0]      cmd_wdata,
  input  logic                       cmd_ready,
  input  logic                       bus_valid,
  input  logic [LINE_WIDTH-1:0]      bus_rdata
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    grant_q;
  logic                    last_grant;
  logic                    cmd_store_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [LINE_WIDTH-1:0]   cmd_wdata_q;
  logic [LINE_WIDTH-1:0]   resp_data_q;
  logic                    grant_valid;
  logic                    grant_idx;
  logic                    accept;
  logic                    load_rdata;
  logic                    finish;

  rr_arbiter2 u_rr (
    .req         (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are masked during reset so a transaction caught by reset
  // never shows a grant or a completion.
  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    cmd_valid  = 1'b0;
    accept     = 1'b0;
    load_rdata = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid && !reset) begin
          req_ready = idx_to_onehot(grant_idx);
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = !reset;
        if (cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus_valid) begin
          // Writebacks complete without data, so the last refill line stays visible.
          load_rdata = !cmd_store_q;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        resp_valid = reset ? 2'b00 : idx_to_onehot(grant_q);
        finish     = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to the D-cache so the I-cache wins the first tie, and it
  // only moves on completion: an aborted transaction does not count as a turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= REQ_ICACHE;
      last_grant  <= REQ_DCACHE;
      cmd_store_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        grant_q     <= grant_idx;
        cmd_store_q <= req_store[grant_idx];
        cmd_addr_q  <= req_addr[grant_idx];
        cmd_wdata_q <= req_wdata[grant_idx];
      end
      if (load_rdata) resp_data_q <= bus_rdata;
      if (finish)     last_grant  <= grant_q;
    end
  end

  assign cmd_store = cmd_store_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int LW = 2048;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_store;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][LW-1:0]  req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [LW-1:0]       resp_data;
  logic                cmd_valid;
  logic                cmd_store;
  logic [AW-1:0]       cmd_addr;
  logic [LW-1:0]       cmd_wdata;
  logic                cmd_ready;
  logic                bus_valid;
  logic [LW-1:0]       bus_rdata;

  int checks = 0;
  int failures = 0;

  // Reference model state: whose turn was last, and what the shared response line holds.
  int            last_g;
  logic [LW-1:0] m_resp;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .cmd_valid  (cmd_valid),
    .cmd_store  (cmd_store),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_ready  (cmd_ready),
    .bus_valid  (bus_valid),
    .bus_rdata  (bus_rdata)
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    a[7:0] = 8'h00;
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: grant, k cycles of ISSUE (cmd_ready on the k-th),
  // WAIT until bus_valid at cycle m, then the completion cycle.
  // With abort set, reset is pulsed in the first WAIT cycle instead.
  task automatic run_txn(input logic [1:0] vld, input int k, input int m,
                         input bit spurious, input bit abort, input logic [LW-1:0] rdata_in);
    int            w;
    logic [1:0]    exp_oh;
    logic          e_store;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    req_valid = vld;
    if (vld == 2'b11) w = 1 - last_g;
    else              w = vld[1] ? 1 : 0;
    exp_oh  = (w == 1) ? 2'b10 : 2'b01;
    e_store = req_store[w];
    e_addr  = req_addr[w];
    e_wdata = req_wdata[w];
    @(negedge clk);
    checks++;
    if (req_ready !== exp_oh) begin
      failures++; $display("FAIL grant got=%b exp=%b", req_ready, exp_oh);
    end
    checks++;
    if (cmd_valid !== 1'b0 || resp_valid !== 2'b00) begin
      failures++; $display("FAIL idle_outputs cmd_valid=%b resp_valid=%b exp 0/00", cmd_valid, resp_valid);
    end
    step();
    // The winner drops its request and its inputs move on; the arbiter must use its own copy.
    req_valid[w] = 1'b0;
    req_store[w] = 1'($urandom);
    req_addr[w]  = rand_addr();
    req_wdata[w] = rand_line();

    for (int c = 1; c <= k; c++) begin
      cmd_ready = (c == k);
      bus_valid = spurious ? 1'($urandom) : 1'b0;
      bus_rdata = rand_line();
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_store !== e_store || cmd_addr !== e_addr) begin
        failures++; $display("FAIL issue_cmd cyc=%0d valid=%b store=%b addr=%h exp 1/%b/%h",
                             c, cmd_valid, cmd_store, cmd_addr, e_store, e_addr);
      end
      checks++;
      if (cmd_wdata !== e_wdata) begin
        failures++; $display("FAIL issue_wdata cyc=%0d got_lo=%h exp_lo=%h", c, cmd_wdata[63:0], e_wdata[63:0]);
      end
      checks++;
      if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
        failures++; $display("FAIL issue_quiet resp_valid=%b req_ready=%b exp 00/00", resp_valid, req_ready);
      end
      step();
    end

    if (abort) begin
      reset     = 1'b1;
      bus_valid = 1'b0;
      cmd_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (resp_valid !== 2'b00 || cmd_valid !== 1'b0) begin
        failures++; $display("FAIL abort_cycle resp_valid=%b cmd_valid=%b exp 00/0", resp_valid, cmd_valid);
      end
      step();
      reset     = 1'b0;
      req_valid = 2'b00;
      bus_valid = 1'b1;
      last_g    = 1;
      m_resp    = '0;
      return;
    end

    for (int c = k + 1; c <= m; c++) begin
      bus_valid = (c == m);
      cmd_ready = 1'($urandom);
      bus_rdata = (c == m) ? rdata_in : rand_line();
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
        failures++; $display("FAIL wait_quiet cmd_valid=%b resp_valid=%b req_ready=%b exp 0/00/00",
                             cmd_valid, resp_valid, req_ready);
      end
      step();
    end

    if (!e_store) m_resp = rdata_in;
    bus_valid = 1'($urandom);
    bus_rdata = rand_line();
    cmd_ready = 1'($urandom);
    @(negedge clk);
    checks++;
    if (resp_valid !== exp_oh) begin
      failures++; $display("FAIL resp_valid got=%b exp=%b", resp_valid, exp_oh);
    end
    checks++;
    if (resp_data !== m_resp) begin
      failures++; $display("FAIL resp_data got_lo=%h exp_lo=%h", resp_data[63:0], m_resp[63:0]);
    end
    checks++;
    if (cmd_valid !== 1'b0 || req_ready !== 2'b00) begin
      failures++; $display("FAIL resp_quiet cmd_valid=%b req_ready=%b exp 0/00", cmd_valid, req_ready);
    end
    last_g = w;
    step();
    bus_valid = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    bus_valid = 1'b1;
    cmd_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || cmd_valid !== 1'b0 || cmd_store !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl req_ready=%b resp_valid=%b cmd_valid=%b cmd_store=%b exp 00/00/0/0",
                           req_ready, resp_valid, cmd_valid, cmd_store);
    end
    checks++;
    if (cmd_addr !== '0 || cmd_wdata !== '0 || resp_data !== '0) begin
      failures++; $display("FAIL reset_data addr=%h wdata_lo=%h resp_lo=%h exp 0",
                           cmd_addr, cmd_wdata[63:0], resp_data[63:0]);
    end
    step();
    reset     = 1'b0;
    bus_valid = 1'b0;
    cmd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
      failures++; $display("FAIL post_reset_idle cmd_valid=%b resp_valid=%b req_ready=%b exp 0/00/00",
                           cmd_valid, resp_valid, req_ready);
    end
    step();
  endtask

  task automatic test_single_load();
    req_store[0] = 1'b0;
    req_addr[0]  = 64'h1000;
    req_wdata[0] = rand_line();
    run_txn(2'b01, 1, 3, 1'b0, 1'b0, {256{8'hA5}});
  endtask

  task automatic test_single_store();
    req_store[1] = 1'b1;
    req_addr[1]  = 64'h2040;
    req_wdata[1] = {256{8'h5A}};
    run_txn(2'b10, 1, 2, 1'b0, 1'b0, rand_line());
  endtask

  task automatic test_tie();
    for (int r = 0; r < 2; r++) begin
      req_store[r] = 1'($urandom);
      req_addr[r]  = rand_addr();
      req_wdata[r] = rand_line();
    end
    run_txn(2'b11, 1, 2, 1'b0, 1'b0, rand_line());
    run_txn(2'b11, 2, 4, 1'b0, 1'b0, rand_line());
  endtask

  task automatic test_backpressure();
    req_valid    = 2'b00;
    req_store[0] = 1'b0;
    req_addr[0]  = rand_addr();
    req_wdata[0] = rand_line();
    run_txn(2'b01, 6, 8, 1'b1, 1'b0, rand_line());
  endtask

  task automatic test_reset_mid_wait();
    req_store[0] = 1'b0;
    req_addr[0]  = rand_addr();
    req_wdata[0] = rand_line();
    run_txn(2'b01, 1, 2, 1'b0, 1'b0, rand_line());
    req_store[1] = 1'b1;
    req_addr[1]  = 64'hDEAD_BE00;
    req_wdata[1] = rand_line();
    run_txn(2'b10, 1, 3, 1'b0, 1'b1, rand_line());
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00 || cmd_valid !== 1'b0 || cmd_store !== 1'b0 || req_ready !== 2'b00) begin
      failures++; $display("FAIL abort_ctrl resp_valid=%b cmd_valid=%b cmd_store=%b req_ready=%b exp 00/0/0/00",
                           resp_valid, cmd_valid, cmd_store, req_ready);
    end
    checks++;
    if (cmd_addr !== '0 || cmd_wdata !== '0 || resp_data !== '0) begin
      failures++; $display("FAIL abort_data addr=%h wdata_lo=%h resp_lo=%h exp 0",
                           cmd_addr, cmd_wdata[63:0], resp_data[63:0]);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (resp_valid !== 2'b00) begin
        failures++; $display("FAIL abort_no_resp cyc=%0d got=%b exp=00", i, resp_valid);
      end
    end
    step();
    bus_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req_store[r] = 1'($urandom);
      req_addr[r]  = rand_addr();
      req_wdata[r] = rand_line();
    end
    run_txn(2'b11, 1, 2, 1'b0, 1'b0, rand_line());
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0] vld;
      int         k;
      int         m;
      vld = req_valid | 2'($urandom_range(0, 3));
      if (vld == 2'b00) vld = 2'($urandom_range(1, 2));
      for (int r = 0; r < 2; r++) begin
        if (vld[r] && !req_valid[r]) begin
          req_store[r] = 1'($urandom);
          req_addr[r]  = rand_addr();
          req_wdata[r] = rand_line();
        end
      end
      k = $urandom_range(1, 3);
      m = k + $urandom_range(1, 3);
      run_txn(vld, k, m, 1'($urandom), 1'b0, rand_line());
      if (req_valid == 2'b00 && $urandom_range(0, 1) == 1) begin
        bus_valid = 1'($urandom);
        cmd_ready = 1'($urandom);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || cmd_valid !== 1'b0 || resp_valid !== 2'b00) begin
          failures++; $display("FAIL rand_idle req_ready=%b cmd_valid=%b resp_valid=%b exp 00/0/00",
                               req_ready, cmd_valid, resp_valid);
        end
        step();
        bus_valid = 1'b0;
        cmd_ready = 1'b0;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_store = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    cmd_ready = 1'b0;
    bus_valid = 1'b0;
    bus_rdata = '0;
    last_g    = 1;
    m_resp    = '0;
    #1;
    test_reset();
    test_single_load();
    test_single_store();
    test_tie();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory bus between the instruction cache (requester 0) and the data cache (requester 1), one whole-line transaction at a time. Each cache presents line refills (loads) and line writebacks (stores). The arbiter grants requesters round-robin, drives the bus command and returns the completion/line data to the granted cache. It sits between the two cache controllers and the memory bus interface.

## Interface
- ADDR_WIDTH, 64, byte address width
- LINE_WIDTH, 2048, cache line width in bits (64-bit words × 32)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  2  per-requester request; held until accepted
- req_store  in  2  per-requester: 1 = writeback, 0 = refill
- req_addr  in  2×ADDR_WIDTH  per-requester line address
- req_wdata  in  2×LINE_WIDTH  per-requester writeback line
- req_ready  out  2  one-hot acceptance pulse
- resp_valid  out  2  one-hot completion pulse
- resp_data  out  LINE_WIDTH  refill line, shared by both requesters, valid with resp_valid
- cmd_valid  out  1  bus command valid
- cmd_store  out  1  bus command type
- cmd_addr  out  ADDR_WIDTH  bus command address
- cmd_wdata  out  LINE_WIDTH  bus writeback data
- cmd_ready  in  1  bus accepts command this cycle
- bus_valid  in  1  bus completion; carries bus_rdata for loads
- bus_rdata  in  LINE_WIDTH  refill line from bus

## Operation
- One outstanding transaction; no pipelining.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With any req_valid set, pick winner g; req_ready[g]=1 combinationally this cycle.
  - Latch req_store/addr/wdata[g] and g; go to ISSUE.
- Round-robin: with both requesters valid, the winner is the one not equal to last_grant. With one requester valid, it wins.
- ISSUE: cmd_valid=1, cmd_* driven from latched registers, held stable; on cmd_ready go to WAIT.
- WAIT: on bus_valid go to RESP. For loads, latch bus_rdata into resp_data; for stores, resp_data is unchanged.
- RESP: resp_valid[g]=1 for one cycle; last_grant←g; go to IDLE.
- Ignored inputs:
  - bus_valid outside WAIT.
  - cmd_ready outside ISSUE.
  - req_valid outside IDLE; requesters keep holding it.
- Reset values:
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - req_ready=0, resp_valid=0, cmd_valid=0, cmd_store=0.
  - cmd_addr=0, cmd_wdata=0, resp_data=0.
- Reset mid-transaction: the transaction is dropped, no resp_valid is produced, and the state returns to IDLE next cycle.

## Timing
- req_ready is the only combinational output; all others are registered or decoded from registered state.
- Request seen in IDLE at cycle T:
  - req_ready at T.
  - cmd_valid from T+1.
  - cmd_ready at T+k (k≥1) moves the FSM to WAIT at T+k+1.
  - bus_valid at T+m (m≥k+1) gives resp_valid at T+m+1.
- Minimum request-to-response latency is 3 cycles.
- resp_valid cycle is followed by IDLE, so back-to-back grants are at least 4 cycles apart.
- A request arriving in the same cycle as resp_valid is accepted on the next cycle, in IDLE.

## Structure
- Package mem_bus_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - REQ_ICACHE=0 and REQ_DCACHE=1.
  - Default LINE_WIDTH and ADDR_WIDTH localparams shared with the caches.
- Sub-module rr_arbiter2: inputs req[1:0] and last_grant; outputs grant_valid and grant_idx. Purely combinational, instantiated once.

## Test plan
- Single load: req0 load addr 0x1000; cmd_ready at T+1; bus_valid with rdata=A5… at T+3 -> resp_valid=01 at T+4, resp_data=A5…, cmd_store=0, cmd_addr=0x1000.
- Single store: req1 store addr 0x2040, wdata=5A… -> cmd_wdata=5A…, cmd_store=1; on bus_valid, resp_valid=10 and resp_data is unchanged.
- Tie after reset: both valid at T -> req_ready=01, cmd_addr=req_addr0. After completion, with both still valid, req_ready=10.
- Backpressure: cmd_ready held low 5 cycles -> cmd_valid/cmd_addr stable for 5 cycles. A spurious bus_valid during ISSUE is ignored, and no resp_valid is produced.
- Reset mid-WAIT: reset asserted one cycle -> all outputs return to reset values, no resp_valid, and the next request is granted normally with last_grant=1.
